// File: rtl/common.sv
// Shared memory-access definitions: func3 encodings, controller state type and
// small decode helpers used by the load/store controller.
package common;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } mem_ctrl_state_t;

  // Illegal size encodings and misaligned halfword/word accesses never reach the bus.
  function automatic logic is_access_fault(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b0;
    case (f3)
      3'b011, 3'b110, 3'b111: fault = 1'b1;
      F3_LH, F3_LHU:          fault = addr_lo[0];
      F3_LW:                  fault = |addr_lo;
      default:                fault = 1'b0;
    endcase
    return fault;
  endfunction

  function automatic logic [3:0] byte_enable(input logic is_store, input logic [2:0] f3,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    if (is_store) begin
      case (f3)
        F3_SB:   be = 4'b0001 << addr_lo;
        F3_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
        F3_SW:   be = 4'b1111;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword/word from a bus read word and
// sign- or zero-extends it according to the load func3.
module load_align
  import common::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (func3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: turns an execute-stage memory instruction into a
// single request/grant/response bus transaction, stalling the pipeline meanwhile.
module mem_access_ctrl
  import common::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_fault,
  output logic        bus_timeout,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  mem_ctrl_state_t state_q, state_d;

  logic [29:0]   addr_hi_q;
  logic [1:0]    addr_lo_q;
  logic [2:0]    func3_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] count_q;
  logic [31:0]   load_data_q;
  logic          load_valid_q;
  logic [31:0]   aligned_data;

  logic request;
  logic fault_now;
  logic start;
  logic timeout_hit;
  logic complete;

  // Gating with reset_n keeps the combinational strobes quiet while reset is held.
  assign request     = reset_n & ex_valid & (mem_read | mem_write) & ~flush;
  assign fault_now   = (state_q == IDLE) & request & is_access_fault(func3, addr[1:0]);
  assign start       = (state_q == IDLE) & request & ~is_access_fault(func3, addr[1:0]);
  assign timeout_hit = (state_q != IDLE) & (count_q == COUNT_LIMIT);
  assign complete    = (state_q == WAIT) & dmem_rvalid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        count_q <= '0;
      end else if (state_q != IDLE) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // A response in WAIT wins over a coincident timeout so finished data is never lost.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    bus_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stall   = 1'b1;
        end
      end
      ISSUE: begin
        if (timeout_hit) begin
          state_d     = IDLE;
          bus_timeout = 1'b1;
        end else begin
          stall = 1'b1;
          if (dmem_gnt) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          bus_timeout = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      func3_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else if (start) begin
      addr_hi_q <= addr[31:2];
      addr_lo_q <= addr[1:0];
      func3_q   <= func3;
      we_q      <= mem_write;
      be_q      <= byte_enable(mem_write, func3, addr[1:0]);
      wdata_q   <= wdata;
    end
  end

  load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr_lo   (addr_lo_q),
    .func3     (func3_q),
    .load_data (aligned_data)
  );

  // Load results stay put until the next load completes; store acks leave them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      load_valid_q <= complete & ~we_q;
      if (complete & ~we_q) begin
        load_data_q <= aligned_data;
      end
    end
  end

  assign dmem_req     = (state_q == ISSUE) & ~timeout_hit;
  assign dmem_we      = we_q;
  assign dmem_addr    = {addr_hi_q, 2'b00};
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign access_fault = fault_now;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the maximum cycles spent in ISSUE+WAIT before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ex_valid  input  1  execute stage holds a valid instruction this cycle.
REQ-005 mem_read / mem_write  input  1 each  load / store request; both high counts as a store.
REQ-006 func3  input  3  access size/sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-007 addr  input  32  byte address (execute stage ALU result).
REQ-008 wdata  input  32  store data, already placed in its byte lane by the execute stage.
REQ-009 flush  input  1  kill the current execute-stage instruction.
REQ-010 stall  output  1  freeze the pipeline upstream of memory.
REQ-011 load_data  output  32  aligned, extended load result; load_valid  output  1  one-cycle strobe.
REQ-012 access_fault  output  1  one-cycle strobe for misaligned address or illegal func3; bus_timeout  output  1  one-cycle strobe for abort.
REQ-013 dmem_req, dmem_we  output  1 each; dmem_addr  output  32  word-aligned (bits[1:0]=00); dmem_be  output  4; dmem_wdata  output  32.
REQ-014 dmem_gnt  input  1  request accepted; dmem_rvalid  input  1  response (read data or write ack); dmem_rdata  input  32.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT.
REQ-016 Start condition: state IDLE, ex_valid, (mem_read|mem_write), !flush, no fault.
REQ-017 On start: latch addr, func3, we, wdata, computed be; next state ISSUE; stall high the same cycle (combinational).
REQ-018 stall = start condition OR state != IDLE, except low in the cycle that completes or aborts.
REQ-019 ISSUE: dmem_req high, address/be/we/wdata stable from latches until dmem_gnt; on gnt -> WAIT, dmem_req low next cycle.
REQ-020 WAIT: on dmem_rvalid -> IDLE; for loads, load_data registered and load_valid pulsed the next cycle; stall low in the rvalid cycle.
REQ-021 dmem_rvalid in ISSUE, or in IDLE, is ignored.
REQ-022 Byte enables: SB 0001<<addr[1:0]; SH 0011 (addr[1]=0) or 1100 (addr[1]=1); SW 1111; loads drive dmem_be=1111.
REQ-023 Fault: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=00, or func3 in {011,110,111} -> access_fault pulse in that cycle, no request, no stall.
REQ-024 Load extract: LB/LBU byte addr[1:0], LH/LHU halfword addr[1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-025 load_data holds its value until the next load completes.
REQ-026 Timeout counter clears on start, increments each cycle in ISSUE/WAIT; on reaching TIMEOUT_CYCLES-1 -> bus_timeout pulse, state IDLE, stall low that cycle, no load_valid.
REQ-027 flush in ISSUE/WAIT is ignored; an issued transaction always completes or times out.
REQ-028 Back-to-back: a new start is accepted in the first IDLE cycle after completion.

Reset
REQ-029 reset_n low: state IDLE; stall, dmem_req, dmem_we, load_valid, access_fault, bus_timeout = 0; dmem_be = 0000; dmem_addr, dmem_wdata, load_data = 0; counter = 0.
REQ-030 Reset mid-transaction abandons it; a late dmem_rvalid after release is ignored (REQ-021).

Structure
REQ-031 Shared package common holds load func3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU) alongside the existing store ones, and the state enum typedef mem_ctrl_state_t.
REQ-032 One combinational sub-module load_align (rdata, addr[1:0], func3 -> load_data) performs REQ-024.

Verification
REQ-033 LB addr=0x1003, rdata=0x80FF_1234, gnt after 2 cycles, rvalid 1 later -> dmem_addr=0x1000, be=1111, load_data=0xFFFF_FF80, one load_valid, stall high 4 cycles.
REQ-034 SH addr=0x2002, wdata=0xBEEF_0000 -> dmem_we=1, be=1100, dmem_wdata=0xBEEF_0000; after ack no load_valid.
REQ-035 LW addr=0x0001 and func3=011 -> access_fault pulse each, dmem_req never asserted, stall low.
REQ-036 LHU addr=0x10 with no gnt, TIMEOUT_CYCLES=8 -> bus_timeout pulse after 8 cycles, FSM IDLE, stall low.
REQ-037 Reset asserted in WAIT, rvalid arrives after release -> all outputs per REQ-029, no load_valid.
REQ-038 Two back-to-back loads with gnt and rvalid one cycle apart -> second request issued in the cycle after first completion, both results correct.
